// File: rtl/sprite_attr_bank.sv
// Purpose     : shadow/active sprite attribute tables fed by the stack-machine write stream;
//               the shadow table is copied into the active table on each vblank rising edge.
// Latency     : table write visible in shadow 1 cycle after strobe; read port 1 cycle; commit NUM_SPRITES cycles.
// Backpressure: none; writes are accepted every cycle, including while a commit is running.
// Ports       : clock/reset (sync, active-high); write/wr_addr/wr_data write stream;
//               vblank level in; rd_index in, rd_x/rd_y/rd_attr/rd_en registered read data;
//               commit_busy, frame_count (completed commits), addr_err (sticky out-of-range write).
// Option      : define SPRITE_ADDR_ERR_EN to enable the sticky addr_err flag (tied 0 otherwise).
module sprite_attr_bank #(
    parameter int unsigned NUM_SPRITES = 8,
    parameter logic [7:0]  BASE_HI     = 8'hF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        write,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic        vblank,
    input  logic [5:0]  rd_index,
    output logic [9:0]  rd_x,
    output logic [9:0]  rd_y,
    output logic [7:0]  rd_attr,
    output logic        rd_en,
    output logic        commit_busy,
    output logic [15:0] frame_count,
    output logic        addr_err
);

    typedef enum logic {IDLE, COPY} state_e;

    localparam logic [6:0] N_SPR    = 7'(NUM_SPRITES);
    localparam logic [5:0] LAST_IDX = 6'(NUM_SPRITES - 1);

    logic [9:0] sh_x_q   [NUM_SPRITES];
    logic [9:0] sh_y_q   [NUM_SPRITES];
    logic [7:0] sh_attr_q[NUM_SPRITES];
    logic       sh_en_q  [NUM_SPRITES];
    logic [9:0] act_x_q   [NUM_SPRITES];
    logic [9:0] act_y_q   [NUM_SPRITES];
    logic [7:0] act_attr_q[NUM_SPRITES];
    logic       act_en_q  [NUM_SPRITES];

    state_e      state_q, state_d;
    logic [5:0]  k_q, k_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        vblank_q;
    logic        copy_en;
    logic [9:0]  rd_x_q, rd_x_d;
    logic [9:0]  rd_y_q, rd_y_d;
    logic [7:0]  rd_attr_q, rd_attr_d;
    logic        rd_en_q, rd_en_d;

    logic        in_win, wr_bad, wr_hit, start;
    logic [5:0]  wr_idx;
    logic [1:0]  wr_fld;
    logic        unused_data;

    assign in_win      = write && (wr_addr[15:8] == BASE_HI);
    assign wr_idx      = wr_addr[7:2];
    assign wr_fld      = wr_addr[1:0];
    assign wr_bad      = in_win && ({1'b0, wr_idx} >= N_SPR);
    assign wr_hit      = in_win && !wr_bad;
    assign start       = vblank && !vblank_q;
    // Upper data bits carry no field information.
    assign unused_data = ^wr_data[15:10];

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        frame_count_d = frame_count_q;
        copy_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COPY;
                    k_d     = 6'd0;
                end
            end
            COPY: begin
                // A vblank edge seen here is dropped: no re-trigger, no queueing.
                copy_en = 1'b1;
                if (k_q == LAST_IDX) begin
                    state_d       = IDLE;
                    k_d           = 6'd0;
                    frame_count_d = frame_count_q + 16'd1;
                end else begin
                    k_d = k_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Indices beyond the table read back as zero.
    always_comb begin
        rd_x_d    = '0;
        rd_y_d    = '0;
        rd_attr_d = '0;
        rd_en_d   = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (rd_index == 6'(i)) begin
                rd_x_d    = act_x_q[i];
                rd_y_d    = act_y_q[i];
                rd_attr_d = act_attr_q[i];
                rd_en_d   = act_en_q[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            k_q           <= '0;
            frame_count_q <= '0;
            vblank_q      <= 1'b0;
            rd_x_q        <= '0;
            rd_y_q        <= '0;
            rd_attr_q     <= '0;
            rd_en_q       <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x_q[i]     <= '0;
                sh_y_q[i]     <= '0;
                sh_attr_q[i]  <= '0;
                sh_en_q[i]    <= 1'b0;
                act_x_q[i]    <= '0;
                act_y_q[i]    <= '0;
                act_attr_q[i] <= '0;
                act_en_q[i]   <= 1'b0;
            end
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            frame_count_q <= frame_count_d;
            vblank_q      <= vblank;
            rd_x_q        <= rd_x_d;
            rd_y_q        <= rd_y_d;
            rd_attr_q     <= rd_attr_d;
            rd_en_q       <= rd_en_d;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (wr_hit && (wr_idx == 6'(i))) begin
                    case (wr_fld)
                        2'd0:    sh_x_q[i]    <= wr_data[9:0];
                        2'd1:    sh_y_q[i]    <= wr_data[9:0];
                        2'd2:    sh_attr_q[i] <= wr_data[7:0];
                        default: sh_en_q[i]   <= wr_data[0];
                    endcase
                end
                // Non-blocking reads of shadow give the pre-write value when a
                // write and the copy hit the same entry in one cycle.
                if (copy_en && (k_q == 6'(i))) begin
                    act_x_q[i]    <= sh_x_q[i];
                    act_y_q[i]    <= sh_y_q[i];
                    act_attr_q[i] <= sh_attr_q[i];
                    act_en_q[i]   <= sh_en_q[i];
                end
            end
        end
    end

`ifdef SPRITE_ADDR_ERR_EN
    logic addr_err_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_err_q <= 1'b0;
        end else if (wr_bad) begin
            addr_err_q <= 1'b1;
`ifdef TESTBENCH
            $display("sprite_attr_bank: out-of-range write addr=%h data=%h", wr_addr, wr_data);
`endif
        end
    end
    assign addr_err = addr_err_q;
`else
    assign addr_err = 1'b0;
`endif

    assign rd_x        = rd_x_q;
    assign rd_y        = rd_y_q;
    assign rd_attr     = rd_attr_q;
    assign rd_en       = rd_en_q;
    assign commit_busy = (state_q == COPY);
    assign frame_count = frame_count_q;

endmodule
